// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_W = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OPA_MSB = 11;
    localparam int OPA_LSB = 6;
    localparam int OPB_MSB = 5;
    localparam int OPB_LSB = 0;

    localparam logic [INSTR_W-1:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        FETCH,
        WAIT_MEM,
        ISSUE,
        EXEC
    } fetch_state_e;

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [INSTR_W-1:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter: PC register, wrapping increment, pending-branch latch and next-PC select.
// With PREFETCH_EN defined it also reports whether the next PC is a branch target.
module fetch_pc #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd,
    input  logic              cap,
    input  logic              br,
    input  logic [ADDR_W-1:0] target,
`ifdef PREFETCH_EN
    output logic              redirect,
`endif
    output logic [ADDR_W-1:0] pc
);

    logic              pend;
    logic [ADDR_W-1:0] pend_tgt;
    logic [ADDR_W-1:0] next_pc;

    // A branch seen in the finishing cycle beats any earlier latched target.
    always_comb begin
        next_pc = pc + ADDR_W'(1);
        if (br)
            next_pc = target;
        else if (pend)
            next_pc = pend_tgt;
    end

`ifdef PREFETCH_EN
    assign redirect = br | pend;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc   <= RESET_PC;
            pend <= 1'b0;
        end else if (upd) begin
            pc   <= next_pc;
            pend <= 1'b0;
        end else if (cap) begin
            pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cap)
            pend_tgt <= target;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage feeding the decoder: FETCH -> WAIT_MEM -> ISSUE -> EXEC handshake with memory and execute.
// Optional one-entry prefetch buffer is enabled by defining PREFETCH_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_valid,
    output logic [DATA_W-1:0] instruction,
    output logic              IR,
    input  logic              IF,
    input  logic              BRjEn,
    input  logic [DATA_W-1:0] bus,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_e      state, state_nxt;
    logic              mem_rd_nxt, ir_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] instr_nxt;
    logic              rd_ack, pc_upd, br_cap;

    assign rd_ack = mem_rd & mem_valid;
    assign pc_upd = (state == EXEC) & IF;
    assign br_cap = (state == EXEC) & BRjEn & ~IF;

`ifdef PREFETCH_EN
    logic              redirect;
    logic              buf_valid, bv_nxt;
    logic              flush, flush_nxt;
    logic              pf_hit;
    logic [DATA_W-1:0] pf_buf, pf_data;

    // A word arriving in the finishing cycle is as good as a buffered one.
    assign pf_hit  = buf_valid | rd_ack;
    assign pf_data = buf_valid ? pf_buf : mem_data;
`endif

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .upd      (pc_upd),
        .cap      (br_cap),
        .br       (BRjEn),
        .target   (bus[ADDR_W-1:0]),
`ifdef PREFETCH_EN
        .redirect (redirect),
`endif
        .pc       (pc)
    );

    always_comb begin
        state_nxt    = state;
        mem_rd_nxt   = mem_rd;
        mem_addr_nxt = mem_addr;
        ir_nxt       = IR;
        instr_nxt    = instruction;
`ifdef PREFETCH_EN
        bv_nxt       = buf_valid;
        flush_nxt    = flush;
`endif
        case (state)
            FETCH: begin
                mem_addr_nxt = pc;
                mem_rd_nxt   = 1'b1;
                state_nxt    = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (rd_ack) begin
                    mem_rd_nxt = 1'b0;
`ifdef PREFETCH_EN
                    if (flush) begin
                        flush_nxt = 1'b0;
                        state_nxt = FETCH;
                    end else
`endif
                    begin
                        instr_nxt = mem_data;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                ir_nxt    = 1'b1;
                state_nxt = EXEC;
`ifdef PREFETCH_EN
                mem_addr_nxt = pc + ADDR_W'(1);
                mem_rd_nxt   = 1'b1;
                bv_nxt       = 1'b0;
`endif
            end
            EXEC: begin
`ifdef PREFETCH_EN
                if (rd_ack) begin
                    bv_nxt     = 1'b1;
                    mem_rd_nxt = 1'b0;
                end
                if (IF) begin
                    ir_nxt = 1'b0;
                    bv_nxt = 1'b0;
                    if (redirect) begin
                        // An in-flight prefetch must drain before the target can be requested.
                        if (mem_rd && !mem_valid) begin
                            flush_nxt = 1'b1;
                            state_nxt = WAIT_MEM;
                        end else begin
                            state_nxt = FETCH;
                        end
                    end else if (pf_hit) begin
                        instr_nxt = pf_data;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = WAIT_MEM;
                    end
                end
`else
                if (IF) begin
                    ir_nxt    = 1'b0;
                    state_nxt = FETCH;
                end
`endif
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            mem_rd      <= 1'b0;
            mem_addr    <= RESET_PC;
            IR          <= 1'b0;
            instruction <= DATA_W'(NOP);
`ifdef PREFETCH_EN
            buf_valid   <= 1'b0;
            flush       <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            mem_rd      <= mem_rd_nxt;
            mem_addr    <= mem_addr_nxt;
            IR          <= ir_nxt;
            instruction <= instr_nxt;
`ifdef PREFETCH_EN
            buf_valid   <= bv_nxt;
            flush       <= flush_nxt;
`endif
        end
    end

`ifdef PREFETCH_EN
    always_ff @(posedge clk) begin
        if (state == EXEC && rd_ack)
            pf_buf <= mem_data;
    end
`endif

endmodule
